// File: rtl/clkmeter.sv
// Measures period and high time of a slow asynchronous signal in clkin cycles,
// with a one-cycle valid strobe and a sticky timeout when rising edges stop.
module clkmeter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             sigin,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t             state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic               s, s_d, rise, fall, tmo_hit;
  logic [CNT_W-1:0]   cnt, hcnt, hcap;
  logic [CNT_W-1:0]   cnt_n, hcnt_n, hcap_n, period_n, high_time_n;
  logic               valid_n, timeout_n, busy_n;

  assign s       = sync[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign tmo_hit = (cnt == TMO);

  // Synchroniser and edge-detect delay run independently of en
  always_ff @(posedge clkin) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sigin};
      s_d  <= s;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      hcap      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hcnt      <= hcnt_n;
      hcap      <= hcap_n;
      period    <= period_n;
      high_time <= high_time_n;
      valid     <= valid_n;
      timeout   <= timeout_n;
      busy      <= busy_n;
    end
  end

  // Next state and datapath; a rising edge takes priority over the timeout compare
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    hcnt_n      = hcnt;
    hcap_n      = hcap;
    period_n    = period;
    high_time_n = high_time;
    valid_n     = 1'b0;
    timeout_n   = timeout;

    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      hcnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ARM;
          cnt_n   = '0;
          hcnt_n  = '0;
        end
        ARM: begin
          if (rise) begin
            state_n = MEAS;
            cnt_n   = ONE;
            hcnt_n  = ONE;
          end else if (tmo_hit) begin
            timeout_n   = 1'b1;
            period_n    = '0;
            high_time_n = '0;
            cnt_n       = '0;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        MEAS: begin
          cnt_n = cnt + ONE;
          if (s) hcnt_n = hcnt + ONE;
          if (fall) hcap_n = hcnt;
          if (rise) begin
            period_n    = cnt;
            high_time_n = hcap;
            valid_n     = 1'b1;
            timeout_n   = 1'b0;
            cnt_n       = ONE;
            hcnt_n      = ONE;
          end else if (tmo_hit) begin
            timeout_n   = 1'b1;
            period_n    = '0;
            high_time_n = '0;
            state_n     = ARM;
            cnt_n       = '0;
            hcnt_n      = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          hcnt_n  = '0;
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

endmodule
